pipeexe: RTL and testbench

Execute stage of the 5-stage MIPS32 pipeline, between the ID/EXE register and the EXE/MEM register. It holds the single-cycle ALU, the jal link-address path and destination-register selection. It also holds an iterative multiply/divide unit (MDU) with HI/LO registers. Its outputs drive the EXE/MEM register inputs directly. While the MDU is busy and the EXE instruction needs HI/LO, it asserts a stall to the hazard unit.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipemdu.sv | 88 ++++++++
 rtl/pipeexe.sv | 77 +++++++
 tb/tb_pipeexe.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ALU op codes, MDU op enumeration, MDU FSM states and iteration count.
package pipe_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;
  typedef enum logic [3:0] {
    MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
    MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO
  } mdu_op_t;
  typedef enum logic {IDLE, RUN} mdu_st_t;
  localparam int MDU_ITER = 32;
endpackage

// File: rtl/pipemdu.sv
// pipemdu: iterative radix-2 multiply/divide unit with HI/LO registers.
// Ports: clk, clr (async active-high reset), a/b operands, op MDU op code,
//        go (EXE not stalled), hi/lo results, busy (iteration in flight).
// Divider datapath present only when PIPE_MDU_DIV_EN is defined.
module pipemdu
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  mdu_op_t     op,
  input  logic        go,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);
  mdu_st_t st, st_n;
  logic [31:0] m, aa, bb;
  logic [63:0] acc, acc_n, fix;
  logic [32:0] sum;
  logic [4:0] cnt;
  logic sa, sb, sgn, isdiv, start, last;
  assign busy = st == RUN;
  assign last = cnt == 5'(MDU_ITER - 1);
  // shift-add: acc holds {partial product, remaining multiplier bits}
  assign sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
`ifdef PIPE_MDU_DIV_EN
  logic dv, dz, ge;
  logic [32:0] df;
  logic [31:0] rem_f, quo_f;
  logic [63:0] div_n;
  assign isdiv = op == MDU_DIV || op == MDU_DIVU;
  // restoring step: acc holds {remainder, dividend bits / quotient bits}
  assign ge = acc[63:31] >= {1'b0, m};
  assign df = acc[63:31] - {1'b0, m};
  assign div_n = ge ? {df[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
  assign acc_n = dv ? div_n : {sum, acc[31:1]};
  assign rem_f = sa ? -acc_n[63:32] : acc_n[63:32];
  // divide by zero: quotient all ones, remainder is |a| re-signed, i.e. a itself
  assign quo_f = dz ? {32{1'b1}} : (sa ^ sb) ? -acc_n[31:0] : acc_n[31:0];
  assign fix = dv ? {rem_f, quo_f} : (sa ^ sb) ? -acc_n : acc_n;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      dv <= 1'b0;
      dz <= 1'b0;
    end else if (start) begin
      dv <= isdiv;
      dz <= isdiv && b == 32'd0;
    end
`else
  assign isdiv = 1'b0;
  assign acc_n = {sum, acc[31:1]};
  assign fix = (sa ^ sb) ? -acc_n : acc_n;
`endif
  assign sgn = op == MDU_MULT || (isdiv && op == MDU_DIV);
  assign start = go && !busy && (op == MDU_MULT || op == MDU_MULTU || isdiv);
  assign aa = sgn && a[31] ? -a : a;
  assign bb = sgn && b[31] ? -b : b;
  always_ff @(posedge clk or posedge clr)
    if (clr) st <= IDLE;
    else st <= st_n;
  always_comb st_n = busy ? (last ? IDLE : RUN) : (start ? RUN : IDLE);
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      m <= 32'd0;
      acc <= 64'd0;
      cnt <= 5'd0;
      sa <= 1'b0;
      sb <= 1'b0;
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      if (start) begin
        sa <= sgn & a[31];
        sb <= sgn & b[31];
        m <= isdiv ? bb : aa;
        acc <= {32'd0, isdiv ? aa : bb};
        cnt <= 5'd0;
      end else if (busy) begin
        acc <= acc_n;
        cnt <= cnt + 5'd1;
      end
      if (busy && last) {hi, lo} <= fix;
      else if (go && !busy && op == MDU_MTHI) hi <= a;
      else if (go && !busy && op == MDU_MTLO) lo <= a;
    end
endmodule

// File: rtl/pipeexe.sv
// pipeexe: MIPS32 execute stage - ALU, jal link, destination select, MDU and stall.
// Ports: clk, clr (async active-high reset); ea/eb forwarded operands, eimm,
//        ealuc/ealuimm/eshift ALU controls, ejal/epc4 link path, ern0 dest reg,
//        emdu MDU op, ewreg_i/em2reg_i/ewmem_i decode controls; outputs ealu,
//        eb_o store data, ern, ewreg/em2reg/ewmem (bubbled on stall), estall, mbusy.
// Config: define PIPE_MDU_DIV_EN to implement DIV/DIVU; otherwise they act as NONE.
module pipeexe
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic [XLEN-1:0] eimm,
  input  logic [3:0]      ealuc,
  input  logic            ealuimm,
  input  logic            eshift,
  input  logic            ejal,
  input  logic [XLEN-1:0] epc4,
  input  logic [4:0]      ern0,
  input  logic [3:0]      emdu,
  input  logic            ewreg_i,
  input  logic            em2reg_i,
  input  logic            ewmem_i,
  output logic [XLEN-1:0] ealu,
  output logic [XLEN-1:0] eb_o,
  output logic [4:0]      ern,
  output logic            ewreg,
  output logic            em2reg,
  output logic            ewmem,
  output logic            estall,
  output logic            mbusy
);
  mdu_op_t mop;
  logic [XLEN-1:0] aa, bb, alu, hi, lo;
`ifdef PIPE_MDU_DIV_EN
  assign mop = mdu_op_t'(emdu);
`else
  assign mop = (emdu == MDU_DIV || emdu == MDU_DIVU) ? MDU_NONE : mdu_op_t'(emdu);
`endif
  // stall depends only on the decoded op and registered busy, so no loop back through go
  assign estall = mbusy && mop != MDU_NONE;
  pipemdu u_mdu (
    .clk  (clk),
    .clr  (clr),
    .a    (ea),
    .b    (eb),
    .op   (mop),
    .go   (!estall),
    .hi   (hi),
    .lo   (lo),
    .busy (mbusy)
  );
  assign aa = eshift ? {27'd0, eimm[10:6]} : ea;
  assign bb = ealuimm ? eimm : eb;
  always_comb
    case (ealuc)
      ALU_SUB: alu = aa - bb;
      ALU_AND: alu = aa & bb;
      ALU_OR:  alu = aa | bb;
      ALU_XOR: alu = aa ^ bb;
      ALU_LUI: alu = bb << 16;
      ALU_SLL: alu = bb << aa[4:0];
      ALU_SRL: alu = bb >> aa[4:0];
      ALU_SRA: alu = $signed(bb) >>> aa[4:0];
      ALU_SLT: alu = {31'd0, $signed(aa) < $signed(bb)};
      default: alu = aa + bb;
    endcase
  assign ealu = ejal ? epc4 + 32'd4 : mop == MDU_MFHI ? hi : mop == MDU_MFLO ? lo : alu;
  assign eb_o = eb;
  assign ern = ejal ? 5'd31 : ern0;
  assign ewreg = ewreg_i && !estall;
  assign em2reg = em2reg_i && !estall;
  assign ewmem = ewmem_i && !estall;
endmodule

// File: tb/tb_pipeexe.sv
// tb_pipeexe: directed self-checking bench for the pipeexe execute stage.
module tb_pipeexe;
  import pipe_pkg::*;
  logic clk = 1'b0;
  logic clr;
  logic [31:0] ea, eb, eimm, epc4, ealu, eb_o;
  logic [3:0] ealuc, emdu;
  logic ealuimm, eshift, ejal, ewreg_i, em2reg_i, ewmem_i;
  logic [4:0] ern0, ern;
  logic ewreg, em2reg, ewmem, estall, mbusy;
  int errors = 0;
  int checks = 0;
  int n, bad;
  always #5 clk = ~clk;
  pipeexe dut (
    .clk(clk), .clr(clr), .ea(ea), .eb(eb), .eimm(eimm), .ealuc(ealuc),
    .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal), .epc4(epc4), .ern0(ern0),
    .emdu(emdu), .ewreg_i(ewreg_i), .em2reg_i(em2reg_i), .ewmem_i(ewmem_i),
    .ealu(ealu), .eb_o(eb_o), .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
    .ewmem(ewmem), .estall(estall), .mbusy(mbusy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic nop();
    ea = 0; eb = 0; eimm = 0; ealuc = ALU_ADD; ealuimm = 0; eshift = 0;
    ejal = 0; epc4 = 0; ern0 = 0; emdu = MDU_NONE;
    ewreg_i = 0; em2reg_i = 0; ewmem_i = 0;
  endtask
  task automatic stall_run(output int cyc, output int bub);
    cyc = 0;
    bub = 0;
    while (estall && cyc < 40) begin
      if (ewreg || em2reg || ewmem) bub++;
      cyc++;
      tick();
    end
  endtask
  task automatic mdu_start(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    nop();
    emdu = op; ea = a; eb = b;
    tick();
    nop();
  endtask
  task automatic rd(input mdu_op_t op, input string tag, input logic [31:0] exp, input int exp_stall);
    int c, x;
    nop();
    emdu = op;
    #1;
    stall_run(c, x);
    chk({tag, "_stall"}, c, exp_stall);
    chk(tag, ealu, exp);
  endtask
  initial begin
    clr = 1'b1;
    nop();
    emdu = MDU_MFHI;
    #3;
    chk("rst_busy", mbusy, 0);
    chk("rst_stall", estall, 0);
    chk("rst_hi", ealu, 0);
    #4 clr = 1'b0;
    tick();
    nop(); ea = 7; eb = 32'hFFFF_FFFD; ewreg_i = 1; ern0 = 5; #1;
    chk("add", ealu, 4);
    chk("add_ern", ern, 5);
    chk("add_wreg", ewreg, 1);
    nop(); ea = 3; eb = 5; ealuc = ALU_SUB; #1;
    chk("sub", ealu, 32'hFFFF_FFFE);
    nop(); eb = 32'h8000_0000; eshift = 1; eimm = 32'h0000_0100; ealuc = ALU_SRA; #1;
    chk("sra", ealu, 32'hF800_0000);
    nop(); ea = 32'hFFFF_FFFF; eb = 1; ealuc = ALU_SLT; #1;
    chk("slt_t", ealu, 1);
    nop(); ea = 1; eb = 32'hFFFF_FFFF; ealuc = ALU_SLT; #1;
    chk("slt_f", ealu, 0);
    nop(); ealuimm = 1; eimm = 32'h1234; eb = 32'hDEAD_BEEF; ealuc = ALU_LUI; #1;
    chk("lui", ealu, 32'h1234_0000);
    chk("eb_o", eb_o, 32'hDEAD_BEEF);
    nop(); ejal = 1; epc4 = 32'h0040_0004; ern0 = 5; ewreg_i = 1; ea = 9; eb = 9; #1;
    chk("jal", ealu, 32'h0040_0008);
    chk("jal_ern", ern, 31);
    chk("jal_wreg", ewreg, 1);
    nop(); emdu = MDU_MULT; ea = 32'hFFFF_FFFD; eb = 5; #1;
    chk("mult_nostall", estall, 0);
    tick();
    chk("mult_busy", mbusy, 1);
    nop(); emdu = MDU_MFLO; ewreg_i = 1; em2reg_i = 1; ewmem_i = 1; #1;
    stall_run(n, bad);
    chk("mult_stall", n, 32);
    chk("mult_bubble", bad, 0);
    chk("mult_lo", ealu, 32'hFFFF_FFF1);
    chk("mult_wreg", ewreg, 1);
    rd(MDU_MFHI, "mult_hi", 32'hFFFF_FFFF, 0);
`ifdef PIPE_MDU_DIV_EN
    mdu_start(MDU_DIV, 32'hFFFF_FFF9, 2);
    rd(MDU_MFLO, "div_lo", 32'hFFFF_FFFD, 32);
    rd(MDU_MFHI, "div_hi", 32'hFFFF_FFFF, 0);
    mdu_start(MDU_DIVU, 9, 0);
    rd(MDU_MFLO, "divu0_lo", 32'hFFFF_FFFF, 32);
    rd(MDU_MFHI, "divu0_hi", 9, 0);
    mdu_start(MDU_DIV, 32'hFFFF_FFF8, 0);
    rd(MDU_MFLO, "div0_lo", 32'hFFFF_FFFF, 32);
    rd(MDU_MFHI, "div0_hi", 32'hFFFF_FFF8, 0);
`else
    mdu_start(MDU_DIV, 32'hFFFF_FFF9, 2);
    chk("nodiv_busy", mbusy, 0);
    nop(); emdu = MDU_DIVU; ea = 9; #1;
    chk("nodiv_stall", estall, 0);
    tick();
    chk("nodivu_busy", mbusy, 0);
    rd(MDU_MFLO, "nodiv_lo", 32'hFFFF_FFF1, 0);
    rd(MDU_MFHI, "nodiv_hi", 32'hFFFF_FFFF, 0);
`endif
    mdu_start(MDU_MULTU, 32'hFFFF_FFFF, 2);
    repeat (9) tick();
    chk("clr_pre_busy", mbusy, 1);
    clr = 1'b1;
    #1;
    chk("clr_busy", mbusy, 0);
    clr = 1'b0;
    rd(MDU_MFHI, "clr_hi", 0, 0);
    rd(MDU_MFLO, "clr_lo", 0, 0);
    mdu_start(MDU_MULT, 7, 32'hFFFF_FFFF);
    emdu = MDU_MULTU; ea = 32'h0001_0000; eb = 32'h0001_0000; #1;
    stall_run(n, bad);
    chk("b2b_stall", n, 32);
    tick();
    rd(MDU_MFHI, "b2b_hi", 1, 32);
    rd(MDU_MFLO, "b2b_lo", 0, 0);
    mdu_start(MDU_MULT, 2, 3);
    emdu = MDU_MTHI; ea = 32'hA5A5_A5A5; #1;
    stall_run(n, bad);
    chk("mthi_stall", n, 32);
    tick();
    rd(MDU_MFHI, "mthi_hi", 32'hA5A5_A5A5, 0);
    rd(MDU_MFLO, "mthi_lo", 6, 0);
    nop(); emdu = MDU_MTLO; ea = 32'h0BAD_F00D;
    tick();
    rd(MDU_MFLO, "mtlo_lo", 32'h0BAD_F00D, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
